// File: rtl/scan_loader.sv
// scan_loader: byte-wide loader for a serial memory-bank scan chain.
// Each byte taken on in_data is shifted out LSB first on scan_in while
// scan_enable is high. The session stops after exactly CHAIN_LEN shift cycles.
// If the chain length is not a multiple of 8, only the low bits of the final
// byte are shifted.
// Optional readback build: define SCAN_LOADER_READBACK_EN. In that build the
// bits arriving on scan_out are captured and offered as bytes on
// out_valid/out_data. Without the macro, out_valid/out_data are tied to 0, and
// scan_out and out_ready are ignored.
module scan_loader #(
  parameter int CHAIN_LEN = 272,
  parameter int CNT_W     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx_nxt;
  logic             chain_end;
  logic             byte_end;

  // Next-count and end-of-byte / end-of-chain decode for the current shift cycle
  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx + 3'd1;
    chain_end = (cnt_nxt == LAST_CNT);
    byte_end  = (idx == 3'd7) || chain_end;
  end

  assign busy = (state != IDLE);

`ifdef SCAN_LOADER_READBACK_EN
  logic [7:0] rb;
  logic [7:0] rb_nxt;

  // Readback byte with the current scan_out bit merged in at the bit index
  always_comb begin
    rb_nxt      = rb;
    rb_nxt[idx] = scan_out;
  end

  // Session FSM with readback: byte load, shift, then offer captured byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rb          <= '0;
      in_ready    <= 1'b0;
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            state       <= SHIFT;
            shreg       <= in_data;
            idx         <= '0;
            rb          <= '0;
            in_ready    <= 1'b0;
            scan_enable <= 1'b1;
            scan_in     <= in_data[0];
          end
        end
        SHIFT: begin
          cnt <= cnt_nxt;
          idx <= idx_nxt;
          rb  <= rb_nxt;
          if (byte_end) begin
            state       <= EMIT;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
            out_valid   <= 1'b1;
            out_data    <= rb_nxt;
          end else begin
            scan_in <= shreg[idx_nxt];
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt == LAST_CNT) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{scan_out, out_ready};
  assign out_valid     = 1'b0;
  assign out_data      = '0;

  // Session FSM without readback: shift exit goes straight back to LOAD or DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      in_ready    <= 1'b0;
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            cnt      <= '0;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            state       <= SHIFT;
            shreg       <= in_data;
            idx         <= '0;
            in_ready    <= 1'b0;
            scan_enable <= 1'b1;
            scan_in     <= in_data[0];
          end
        end
        SHIFT: begin
          cnt <= cnt_nxt;
          idx <= idx_nxt;
          if (byte_end) begin
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
            if (chain_end) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end else begin
            scan_in <= shreg[idx_nxt];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader: a 16-bit chain instance (a) and a 12-bit
// chain instance (b), each terminated by a behavioural scan-chain model.
module tb_scan_loader;

`ifdef SCAN_LOADER_READBACK_EN
  localparam int DLAT = 2;
`else
  localparam int DLAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, out_ready, sel, mload;
  logic [7:0] in_data;
  logic [15:0] mval;

  logic       start_a, ir_a, ov_a, se_a, si_a, so_a, by_a, dn_a;
  logic       start_b, ir_b, ov_b, se_b, si_b, so_b, by_b, dn_b;
  logic [7:0] od_a, od_b;
  logic [15:0] model_a;
  logic [11:0] model_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  scan_loader #(.CHAIN_LEN(16), .CNT_W(5)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
    .scan_enable(se_a), .scan_in(si_a), .scan_out(so_a), .busy(by_a), .done(dn_a));

  scan_loader #(.CHAIN_LEN(12), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready),
    .scan_enable(se_b), .scan_in(si_b), .scan_out(so_b), .busy(by_b), .done(dn_b));

  logic       ir, ov, se, si, by, dn;
  logic [7:0] od;
  assign ir = sel ? ir_b : ir_a;
  assign ov = sel ? ov_b : ov_a;
  assign se = sel ? se_b : se_a;
  assign si = sel ? si_b : si_a;
  assign by = sel ? by_b : by_a;
  assign dn = sel ? dn_b : dn_a;
  assign od = sel ? od_b : od_a;

  // Scan-chain models: shift toward bit 0, tail is bit 0
  always @(posedge clk) begin
    if (mload) begin
      model_a <= mval;
      model_b <= mval[11:0];
    end else begin
      if (se_a) model_a <= {si_a, model_a[15:1]};
      if (se_b) model_b <= {si_b, model_b[11:1]};
    end
  end
  assign so_a = model_a[0];
  assign so_b = model_b[0];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, se_cnt = 0, od_cnt = 0, done_cnt = 0, ov_cyc = 0, excl = 0;
  int last_se = 0, done_at = 0, fi = 0;
  logic [31:0] si_vec = '0;
  logic [7:0]  od_vec [4];
  logic [7:0]  feed [4];

  // Session monitor and byte feeder, sampled away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (start && !by) begin
      se_cnt = 0; od_cnt = 0; done_cnt = 0; ov_cyc = 0; si_vec = '0; fi = 0;
    end
    if (se) begin
      if (se_cnt < 32) si_vec[se_cnt] = si;
      se_cnt++;
      last_se = cyc;
    end
    if (ov) ov_cyc++;
    if (ov && out_ready) begin
      if (od_cnt < 4) od_vec[od_cnt] = od;
      od_cnt++;
    end
    if (dn) begin done_cnt++; done_at = cyc; end
    if (ir && ov) excl++;
    if (ir && in_valid) begin
      if (fi < 4) in_data = feed[fi];
      fi++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic load_model(input logic [15:0] v);
    tick(); mval = v; mload = 1'b1; tick(); mload = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dn) begin ok = 1'b1; break; end
      tick();
    end
    @(negedge clk); #1;
  endtask

  task automatic session(input logic [7:0] b0, input logic [7:0] b1, output bit ok);
    feed[0] = b0; feed[1] = b1;
    in_valid = 1'b1;
    pulse_start();
    wait_done(100, ok);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    mload = 1'b0; mval = '0;
    repeat (3) tick();
    n_chk++;
    if ({by_a, dn_a, ir_a, ov_a, se_a, si_a, od_a} !== 14'h0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {by_a, dn_a, ir_a, ov_a, se_a, si_a, od_a});
    end
    n_chk++;
    if ({by_b, dn_b, ir_b, ov_b, se_b, si_b, od_b} !== 14'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {by_b, dn_b, ir_b, ov_b, se_b, si_b, od_b});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    sel = 1'b0; out_ready = 1'b1;
    load_model(16'h1234);
    session(8'hA5, 8'h3C, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen: got %0d expected 1", ok); end
    n_chk++; if (si_vec[15:0] !== 16'h3CA5) begin n_fail++; $display("FAIL basic_scan_in: got %h expected 3ca5", si_vec[15:0]); end
    n_chk++; if (se_cnt !== 16) begin n_fail++; $display("FAIL basic_se_cycles: got %0d expected 16", se_cnt); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    n_chk++; if (done_at - last_se !== DLAT) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected %0d", done_at - last_se, DLAT); end
    n_chk++; if (model_a !== 16'h3CA5) begin n_fail++; $display("FAIL basic_model: got %h expected 3ca5", model_a); end
    n_chk++; if (excl !== 0) begin n_fail++; $display("FAIL basic_ready_valid_excl: got %0d expected 0", excl); end
`ifdef SCAN_LOADER_READBACK_EN
    n_chk++; if (od_cnt !== 2) begin n_fail++; $display("FAIL basic_rb_count: got %0d expected 2", od_cnt); end
    n_chk++; if (od_vec[0] !== 8'h34) begin n_fail++; $display("FAIL basic_rb0: got %h expected 34", od_vec[0]); end
    n_chk++; if (od_vec[1] !== 8'h12) begin n_fail++; $display("FAIL basic_rb1: got %h expected 12", od_vec[1]); end
`else
    n_chk++; if (ov_cyc !== 0) begin n_fail++; $display("FAIL basic_no_out_valid: got %0d expected 0", ov_cyc); end
    n_chk++; if (od_a !== 8'h00) begin n_fail++; $display("FAIL basic_out_data_tied: got %h expected 00", od_a); end
`endif
    tick();
    n_chk++; if (by_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b expected 0", by_a); end
  endtask

  task automatic test_partial();
    bit ok;
    sel = 1'b1; out_ready = 1'b1;
    load_model(16'h0ABC);
    session(8'hFF, 8'hFF, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL partial_done_seen: got %0d expected 1", ok); end
    n_chk++; if (se_cnt !== 12) begin n_fail++; $display("FAIL partial_se_cycles: got %0d expected 12", se_cnt); end
    n_chk++; if (si_vec[15:0] !== 16'h0FFF) begin n_fail++; $display("FAIL partial_scan_in: got %h expected 0fff", si_vec[15:0]); end
    n_chk++; if (model_b !== 12'hFFF) begin n_fail++; $display("FAIL partial_model: got %h expected fff", model_b); end
`ifdef SCAN_LOADER_READBACK_EN
    n_chk++; if (od_vec[0] !== 8'hBC) begin n_fail++; $display("FAIL partial_rb0: got %h expected bc", od_vec[0]); end
    n_chk++; if (od_vec[1] !== 8'h0A) begin n_fail++; $display("FAIL partial_rb1: got %h expected 0a", od_vec[1]); end
`endif
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    sel = 1'b0; out_ready = 1'b0;
    load_model(16'h1234);
`ifdef SCAN_LOADER_READBACK_EN
    begin
      logic [7:0] od0;
      int w;
      feed[0] = 8'hA5; feed[1] = 8'h3C;
      in_valid = 1'b1;
      pulse_start();
      w = 0;
      while (!ov && w < 40) begin tick(); w++; end
      n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL bp_emit_reached: got %b expected 1", ov); end
      od0 = od;
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if ({se, ov, od} !== {1'b0, 1'b1, od0}) begin
          n_fail++; $display("FAIL bp_hold_cycle%0d: got se=%b ov=%b od=%h expected se=0 ov=1 od=%h", i, se, ov, od, od0);
        end
        tick();
      end
      out_ready = 1'b1;
      wait_done(100, ok);
      in_valid = 1'b0;
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_done_seen: got %0d expected 1", ok); end
      n_chk++; if (od0 !== 8'h34) begin n_fail++; $display("FAIL bp_rb0: got %h expected 34", od0); end
      n_chk++; if (od_vec[1] !== 8'h12) begin n_fail++; $display("FAIL bp_rb1: got %h expected 12", od_vec[1]); end
    end
`else
    session(8'hA5, 8'h3C, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_done_seen: got %0d expected 1", ok); end
    n_chk++; if (ov_cyc !== 0) begin n_fail++; $display("FAIL bp_no_out_valid: got %0d expected 0", ov_cyc); end
`endif
    n_chk++; if (se_cnt !== 16) begin n_fail++; $display("FAIL bp_se_cycles: got %0d expected 16", se_cnt); end
    n_chk++; if (si_vec[15:0] !== 16'h3CA5) begin n_fail++; $display("FAIL bp_scan_in: got %h expected 3ca5", si_vec[15:0]); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    sel = 1'b0; out_ready = 1'b1;
    load_model(16'h1234);
    feed[0] = 8'hA5; feed[1] = 8'h3C;
    in_valid = 1'b1;
    pulse_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (se) n++;
      if (n == 3) break;
    end
    n_chk++; if (n !== 3) begin n_fail++; $display("FAIL rstmid_third_shift: got %0d expected 3", n); end
    rst = 1'b1; #1;
    n_chk++;
    if ({by_a, dn_a, ir_a, ov_a, se_a, si_a, od_a} !== 14'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", {by_a, dn_a, ir_a, ov_a, se_a, si_a, od_a});
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    n_chk++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    load_model(16'h1234);
    session(8'hA5, 8'h3C, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_done: got %0d expected 1", ok); end
    n_chk++; if (si_vec[15:0] !== 16'h3CA5) begin n_fail++; $display("FAIL rstmid_fresh_scan_in: got %h expected 3ca5", si_vec[15:0]); end
    n_chk++; if (se_cnt !== 16) begin n_fail++; $display("FAIL rstmid_fresh_se: got %0d expected 16", se_cnt); end
`ifdef SCAN_LOADER_READBACK_EN
    n_chk++; if (od_vec[0] !== 8'h34) begin n_fail++; $display("FAIL rstmid_fresh_rb0: got %h expected 34", od_vec[0]); end
`endif
  endtask

  task automatic test_start_busy();
    bit ok;
    sel = 1'b0; out_ready = 1'b1;
    load_model(16'h1234);
    feed[0] = 8'hA5; feed[1] = 8'h3C;
    in_valid = 1'b1;
    pulse_start();
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(100, ok);
    in_valid = 1'b0;
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_done_seen: got %0d expected 1", ok); end
    n_chk++; if (si_vec[15:0] !== 16'h3CA5) begin n_fail++; $display("FAIL busy_scan_in: got %h expected 3ca5", si_vec[15:0]); end
    n_chk++; if (se_cnt !== 16) begin n_fail++; $display("FAIL busy_se_cycles: got %0d expected 16", se_cnt); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
    repeat (3) tick();
    n_chk++; if (by_a !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart: got %b expected 0", by_a); end
    n_chk++; if (excl !== 0) begin n_fail++; $display("FAIL busy_ready_valid_excl: got %0d expected 0", excl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
